// File: rtl/output_pack_writer_pkg.sv
// Shared types and helpers for output_pack_writer: FSM states, lane/address
// width derivations and the result-to-pixel conversion.
package output_pack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Lane index width for a given pixels-per-word count
    function automatic int unsigned lane_w(input int unsigned pack);
        return $clog2(pack);
    endfunction

    // Pixel address width: RAM word address plus lane index
    function automatic int unsigned pix_aw(input int unsigned ram_aw, input int unsigned pack);
        return ram_aw + lane_w(pack);
    endfunction

    // Binary threshold (strictly greater) or clamp to [0, 2^pix_w-1]
    function automatic logic [63:0] pix_convert(input logic signed [63:0] value,
                                                 input logic signed [63:0] thresh,
                                                 input int unsigned        pix_w,
                                                 input logic               saturate);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< pix_w) - 64'sd1;
        if (saturate) begin
            if (value < 64'sd0)
                return '0;
            else if (value > max_v)
                return max_v;
            else
                return value;
        end
        return (value > thresh) ? '1 : '0;
    endfunction

endpackage

// File: rtl/output_pack_writer_if.sv
// Result stream, RAM port and host readback bundle for output_pack_writer.
interface output_pack_writer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned PACK   = 8,
    parameter int unsigned RAM_AW = 16
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     ram_we;
    logic [PACK-1:0]          ram_be;
    logic [RAM_AW-1:0]        ram_addr;
    logic [PACK*PIX_W-1:0]    ram_wdata;
    logic [PACK*PIX_W-1:0]    ram_rdata;
    logic [RAM_AW-1:0]        host_addr;
    logic [PACK*PIX_W-1:0]    host_rd_data;
    logic                     busy;
    logic                     output_ready;
    logic                     frame_done;

    modport master (
        output start, in_valid, in_data, ram_rdata, host_addr,
        input  in_ready, ram_we, ram_be, ram_addr, ram_wdata, host_rd_data,
               busy, output_ready, frame_done
    );

    modport slave (
        input  start, in_valid, in_data, ram_rdata, host_addr,
        output in_ready, ram_we, ram_be, ram_addr, ram_wdata, host_rd_data,
               busy, output_ready, frame_done
    );
endinterface

// File: rtl/output_pack_writer_convert.sv
// Combinational result-to-pixel conversion. Define OUTPUT_PACK_SATURATE_EN to
// clamp instead of applying the binary threshold.
module pixel_convert
    import output_pack_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PIX_W  = 8,
    parameter int          THRESH = 128
) (
    input  logic signed [DATA_W-1:0] in_data,
    output logic [PIX_W-1:0]         pix_c
);
`ifdef OUTPUT_PACK_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    assign pix_c = PIX_W'(pix_convert(64'(in_data), 64'(THRESH), PIX_W, SATURATE));
endmodule

// File: rtl/output_pack_writer.sv
// Frame writer: converts results to pixels, packs PACK lanes per RAM word with
// byte enables, skips border slots and hands the RAM to the host when done.
// Optional clamp conversion selected by OUTPUT_PACK_SATURATE_EN.
module output_pack_writer
    import output_pack_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned PACK      = 8,
    parameter int unsigned RAM_AW    = 16,
    parameter int unsigned VALID_W   = 638,
    parameter int unsigned SKIP      = 2,
    parameter int unsigned NUM_ROWS  = 478,
    parameter int unsigned START_PIX = 0,
    parameter int          THRESH    = 128
) (
    input logic                 clk,
    input logic                 reset,
    output_pack_writer_if.slave bus
);
    localparam int unsigned LANE_W = lane_w(PACK);
    localparam int unsigned PIX_AW = pix_aw(RAM_AW, PACK);
    localparam int unsigned COL_W  = $clog2(VALID_W + 1);
    localparam int unsigned ROW_W  = $clog2(NUM_ROWS + 1);
    localparam int unsigned WORD_W = PACK * PIX_W;

    localparam logic [63:0] FRAME_END = 64'(START_PIX) + 64'(NUM_ROWS) * 64'(VALID_W + SKIP);
    localparam logic [63:0] CAPACITY  = 64'(PACK) << RAM_AW;

    if (FRAME_END > CAPACITY) begin : g_bad_span
        $fatal(1, "output_pack_writer: frame does not fit in RAM");
    end
    if ((PACK == 0) || ((PACK & (PACK - 1)) != 0)) begin : g_bad_pack
        $fatal(1, "output_pack_writer: PACK must be a power of two");
    end

    state_e              state;
    logic [PIX_AW-1:0]   pix_addr;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [WORD_W-1:0]   pack_q;
    logic [PACK-1:0]     be_q;
    logic [RAM_AW-1:0]   wr_addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [PACK-1:0]     ram_be_q;
    logic                ram_we_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                output_ready_q;
    logic                frame_done_q;

    logic [PIX_W-1:0]    pix_c;
    logic [LANE_W-1:0]   lane_c;
    logic [WORD_W-1:0]   pack_ins_c;
    logic [PACK-1:0]     be_ins_c;
    logic                accept_c;
    logic                col_last_c;
    logic                flush_c;
    logic                frame_last_c;

    pixel_convert #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .THRESH (THRESH)
    ) u_convert (
        .in_data (bus.in_data),
        .pix_c   (pix_c)
    );

    assign accept_c     = bus.in_valid && in_ready_q;
    assign lane_c       = pix_addr[LANE_W-1:0];
    assign col_last_c   = (col == COL_W'(VALID_W - 1));
    assign flush_c      = (lane_c == LANE_W'(PACK - 1)) || col_last_c;
    assign frame_last_c = col_last_c && (row == ROW_W'(NUM_ROWS - 1));

    // Pack register and enables with the incoming pixel merged into its lane
    always_comb begin
        pack_ins_c = pack_q;
        pack_ins_c[lane_c*PIX_W +: PIX_W] = pix_c;
        be_ins_c = be_q | (PACK'(1) << lane_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pix_addr       <= '0;
            col            <= '0;
            row            <= '0;
            pack_q         <= '0;
            be_q           <= '0;
            wr_addr_q      <= '0;
            wdata_q        <= '0;
            ram_be_q       <= '0;
            ram_we_q       <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            output_ready_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            ram_we_q     <= 1'b0;
            ram_be_q     <= '0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= FILL;
                        pix_addr       <= PIX_AW'(START_PIX);
                        col            <= '0;
                        row            <= '0;
                        pack_q         <= '0;
                        be_q           <= '0;
                        in_ready_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        output_ready_q <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept_c) begin
                        if (flush_c) begin
                            ram_we_q  <= 1'b1;
                            ram_be_q  <= be_ins_c;
                            wdata_q   <= pack_ins_c;
                            wr_addr_q <= pix_addr[PIX_AW-1:LANE_W];
                            pack_q    <= '0;
                            be_q      <= '0;
                        end else begin
                            pack_q <= pack_ins_c;
                            be_q   <= be_ins_c;
                        end
                        // Row end jumps over the border slots
                        if (col_last_c) begin
                            pix_addr <= pix_addr + PIX_AW'(1 + SKIP);
                            col      <= '0;
                            row      <= row + ROW_W'(1);
                        end else begin
                            pix_addr <= pix_addr + PIX_AW'(1);
                            col      <= col + COL_W'(1);
                        end
                        if (frame_last_c) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state          <= DONE;
                    busy_q         <= 1'b0;
                    output_ready_q <= 1'b1;
                    frame_done_q   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_be       = ram_be_q;
    assign bus.ram_wdata    = wdata_q;
    assign bus.ram_addr     = output_ready_q ? bus.host_addr : wr_addr_q;
    assign bus.host_rd_data = bus.ram_rdata;
    assign bus.busy         = busy_q;
    assign bus.output_ready = output_ready_q;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_output_pack_writer.sv
// Randomized bench for output_pack_writer: two instances (START_PIX 0 and 5)
// share one stimulus stream and are checked against a pixel-index reference model.
module tb_output_pack_writer;
    localparam int VW   = 6;
    localparam int SK   = 2;
    localparam int NR   = 2;
    localparam int NPIX = VW * NR;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic [3:0]         host_addr;
    logic [63:0]        rdata0, rdata1;
    logic [63:0]        mem0 [16];
    logic [63:0]        mem1 [16];

    int n_cmp = 0;
    int n_bad = 0;

    output_pack_writer_if #(.DATA_W(32), .PIX_W(8), .PACK(8), .RAM_AW(4)) bus0 ();
    output_pack_writer_if #(.DATA_W(32), .PIX_W(8), .PACK(8), .RAM_AW(4)) bus1 ();

    output_pack_writer #(.DATA_W(32), .PIX_W(8), .PACK(8), .RAM_AW(4), .VALID_W(VW), .SKIP(SK),
                         .NUM_ROWS(NR), .START_PIX(0), .THRESH(128))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    output_pack_writer #(.DATA_W(32), .PIX_W(8), .PACK(8), .RAM_AW(4), .VALID_W(VW), .SKIP(SK),
                         .NUM_ROWS(NR), .START_PIX(5), .THRESH(128))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus0.start = start;      assign bus1.start = start;
    assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
    assign bus0.in_data = in_data;   assign bus1.in_data = in_data;
    assign bus0.host_addr = host_addr; assign bus1.host_addr = host_addr;
    assign bus0.ram_rdata = rdata0;  assign bus1.ram_rdata = rdata1;

    always #5 clk = ~clk;

    // External RAMs: byte-enabled write, one-cycle read
    always @(posedge clk) begin
        logic [63:0] w;
        w = mem0[bus0.ram_addr];
        for (int l = 0; l < 8; l++) if (bus0.ram_we && bus0.ram_be[l]) w[l*8 +: 8] = bus0.ram_wdata[l*8 +: 8];
        if (bus0.ram_we) mem0[bus0.ram_addr] <= w;
        rdata0 <= mem0[bus0.ram_addr];
        w = mem1[bus1.ram_addr];
        for (int l = 0; l < 8; l++) if (bus1.ram_we && bus1.ram_be[l]) w[l*8 +: 8] = bus1.ram_wdata[l*8 +: 8];
        if (bus1.ram_we) mem1[bus1.ram_addr] <= w;
        rdata1 <= mem1[bus1.ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic signed [31:0] v);
`ifdef OUTPUT_PACK_SATURATE_EN
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return v[7:0];
`else
        return (v > 128) ? 8'hFF : 8'h00;
`endif
    endfunction

    // Reference model state, one slot per instance
    int          k      [2];
    int          post   [2];
    int          pword  [2];
    logic        fill   [2];
    logic        ordy_m [2];
    logic        pw     [2];
    logic [63:0] acc_d  [2];
    logic [63:0] pdata  [2];
    logic [7:0]  acc_b  [2];
    logic [7:0]  pbe    [2];
    logic [63:0] emem   [2][16];

    task automatic step(input int d, input int sp, input logic ir, input logic we, input logic [7:0] be,
                        input logic [3:0] addr, input logic [63:0] wd, input logic busy,
                        input logic ordy, input logic fdone);
        int addr_p, row, col, lane;
        logic idle_like;
        if (reset) begin
            k[d] = 0; post[d] = 0; fill[d] = 1'b0; ordy_m[d] = 1'b0; pw[d] = 1'b0;
            acc_d[d] = '0; acc_b[d] = '0;
            return;
        end
        check($sformatf("d%0d_in_ready", d), 64'(ir), 64'(fill[d]));
        check($sformatf("d%0d_busy", d), 64'(busy), 64'(fill[d] || post[d] == 1));
        check($sformatf("d%0d_output_ready", d), 64'(ordy), 64'(ordy_m[d]));
        check($sformatf("d%0d_frame_done", d), 64'(fdone), 64'(post[d] == 2));
        check($sformatf("d%0d_ram_we", d), 64'(we), 64'(pw[d]));
        if (pw[d]) begin
            check($sformatf("d%0d_wr_addr", d), 64'(addr), 64'(pword[d]));
            check($sformatf("d%0d_wr_be", d), 64'(be), 64'(pbe[d]));
            check($sformatf("d%0d_wr_data", d), wd, pdata[d]);
            for (int l = 0; l < 8; l++)
                if (pbe[d][l]) emem[d][pword[d]][l*8 +: 8] = pdata[d][l*8 +: 8];
        end
        pw[d] = 1'b0;
        idle_like = !fill[d] && post[d] != 1;
        if (post[d] != 0) begin
            post[d] = (post[d] == 3) ? 0 : post[d] + 1;
            if (post[d] == 2) ordy_m[d] = 1'b1;
        end
        if (fill[d] && in_valid) begin
            row = k[d] / VW; col = k[d] % VW;
            addr_p = sp + row * (VW + SK) + col;
            lane = addr_p % 8;
            acc_d[d][lane*8 +: 8] = ref_pix(in_data);
            acc_b[d][lane] = 1'b1;
            if (lane == 7 || col == VW - 1) begin
                pw[d] = 1'b1; pword[d] = addr_p / 8; pbe[d] = acc_b[d]; pdata[d] = acc_d[d];
                acc_d[d] = '0; acc_b[d] = '0;
            end
            k[d]++;
            if (k[d] == NPIX) begin fill[d] = 1'b0; post[d] = 1; end
        end
        if (start && idle_like) begin
            fill[d] = 1'b1; ordy_m[d] = 1'b0; k[d] = 0; post[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        step(0, 0, bus0.in_ready, bus0.ram_we, bus0.ram_be, bus0.ram_addr, bus0.ram_wdata,
             bus0.busy, bus0.output_ready, bus0.frame_done);
        step(1, 5, bus1.in_ready, bus1.ram_we, bus1.ram_be, bus1.ram_addr, bus1.ram_wdata,
             bus1.busy, bus1.output_ready, bus1.frame_done);
    end

    task automatic check_quiet(input string who, input logic ir, input logic we, input logic [7:0] be,
                               input logic [3:0] a, input logic [63:0] wd, input logic b,
                               input logic o, input logic f);
        check({who, "_rst_in_ready"}, 64'(ir), 64'(0));
        check({who, "_rst_ram_we"}, 64'(we), 64'(0));
        check({who, "_rst_ram_be"}, 64'(be), 64'(0));
        check({who, "_rst_ram_addr"}, 64'(a), 64'(0));
        check({who, "_rst_ram_wdata"}, wd, 64'(0));
        check({who, "_rst_busy"}, 64'(b), 64'(0));
        check({who, "_rst_output_ready"}, 64'(o), 64'(0));
        check({who, "_rst_frame_done"}, 64'(f), 64'(0));
    endtask

    task automatic check_both_quiet();
        check_quiet("d0", bus0.in_ready, bus0.ram_we, bus0.ram_be, bus0.ram_addr, bus0.ram_wdata,
                    bus0.busy, bus0.output_ready, bus0.frame_done);
        check_quiet("d1", bus1.in_ready, bus1.ram_we, bus1.ram_be, bus1.ram_addr, bus1.ram_wdata,
                    bus1.busy, bus1.output_ready, bus1.frame_done);
    endtask

    // dmode: 0 all 129, 1 threshold corners then random, 2 random
    // vmode: 0 always valid, 1 toggle, 2 random valid with stray starts
    task automatic run_frame(input int dmode, input int vmode, input int abort_after);
        logic signed [31:0] data [NPIX];
        int idx, cyc;
        logic acc, seen;
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(0, 3) == 0) data[i] = $urandom;
            else data[i] = $signed($urandom_range(0, 400)) - 100;
            if (dmode == 0) data[i] = 129;
        end
        if (dmode == 1) begin
            data[0] = 128; data[1] = 129; data[2] = -5; data[3] = 32'sh7FFFFFFF;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < NPIX) begin
            if (cyc > 400) begin
                check("frame_timeout", 64'(0), 64'(1));
                break;
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            start = (vmode == 2) && ($urandom_range(0, 7) == 0);
            in_data = data[idx];
            @(negedge clk);
            acc = in_valid && bus0.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            start = 1'b0;
            if (abort_after > 0 && idx == abort_after) begin
                reset = 1'b1; in_valid = 1'b0;
                #1 check_both_quiet();
                @(posedge clk); #1 reset = 1'b0;
                return;
            end
        end
        in_valid = 1'b0; start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus0.output_ready && bus1.output_ready;
        end
        check("done_wait", 64'(seen), 64'(1));
        repeat (2) @(posedge clk);
    endtask

    task automatic readback();
        for (int a = 0; a < 4; a++) begin
            @(posedge clk); #1 host_addr = 4'(a);
            #1;
            check("d0_host_ram_addr", 64'(bus0.ram_addr), 64'(a));
            check("d1_host_ram_addr", 64'(bus1.ram_addr), 64'(a));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("d0_rd_word%0d", a), bus0.host_rd_data, emem[0][a]);
            check($sformatf("d1_rd_word%0d", a), bus1.host_rd_data, emem[1][a]);
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            mem0[a] = '0; mem1[a] = '0; emem[0][a] = '0; emem[1][a] = '0;
        end
        start = 1'b0; in_valid = 1'b0; in_data = '0; host_addr = '0;
        #1 reset = 1'b1;
        #1 check_both_quiet();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_frame(0, 0, 0);
        readback();
        run_frame(1, 1, 0);
        readback();
        run_frame(2, 0, 3);
        run_frame(2, 2, 0);
        readback();
        for (int f = 0; f < 3; f++) begin
            run_frame(2, f % 3, 0);
            readback();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
